i2c_data_receiver: RTL
======================

Name: i2c_data_receiver

Overview:
- I2C slave-side byte receiver, the counterpart of the slave data transmitter.
- Samples SDA MSB-first on SCL rising edges while enabled and assembles a byte.
- Presents the byte with a one-cycle valid strobe, then drives the ACK/NACK bit in the 9th SCL period.
- Sits under the I2C slave control FSM, which supplies SCL edge strobes and the enable; supports back-to-back bytes while en_i stays high.

Parameters:
DATA_W, 8, bits per byte before the ACK slot; legal range 1..15; bit counter is 4 bits.

Ports:
clk_i  input  1  system clock; all logic on posedge.
reset_i  input  1  asynchronous, active-high reset.
en_i  input  1  receive enable from the control FSM; low = abort/idle.
scl_pos_edge_detected_i  input  1  one-cycle strobe, SCL rising edge (data sample point).
scl_neg_edge_detected_i  input  1  one-cycle strobe, SCL falling edge (SDA change point).
sda_i  input  1  synchronised SDA line value.
ack_en_i  input  1  1 = ACK (drive 0) in the ACK slot, 0 = NACK (release); sampled at ACK-slot entry.
data_o  output  DATA_W  last completed byte; holds until the next byte completes.
data_valid_o  output  1  one-cycle pulse when data_o updates.
sda_o  output  1  open-drain SDA drive; 0 = pull low, 1 = release.
ack_done_o  output  1  one-cycle pulse when the ACK slot ends and SDA is released.
byte_cnt_o  output  8  bytes received since en_i rose; wraps 255->0.

Behaviour:
- Async reset: state=IDLE, bit_cnt=DATA_W, shift reg=0, data_o=0, data_valid_o=0, sda_o=1, ack_done_o=0, byte_cnt_o=0.
- en_i low in any state, synchronous: go to IDLE next cycle; sda_o=1; bit_cnt=DATA_W; shift reg cleared; byte_cnt_o=0; data_o retained; no pulses.
- States: IDLE, SHIFT, WAIT_ACK, ACK, ACK_HOLD.
- IDLE: sda_o=1. If en_i=1, go to SHIFT next cycle, bit_cnt=DATA_W. Edge strobes in the same cycle en_i rises are ignored.
- SHIFT: on scl_pos strobe, shift reg <= {shift[DATA_W-2:0], sda_i} and bit_cnt decrements. scl_neg strobes are ignored.
  - When the sample that takes bit_cnt 1->0 occurs, on the next clock: data_o <= completed value (including that bit), data_valid_o=1 for exactly one cycle, byte_cnt_o increments (wraps), state -> WAIT_ACK.
- WAIT_ACK: on scl_neg strobe, sda_o <= ~ack_en_i (sampled that cycle), state -> ACK. scl_pos strobes are ignored.
- ACK: on scl_pos strobe (master samples ACK), state -> ACK_HOLD; sda_o unchanged.
- ACK_HOLD: on scl_neg strobe, sda_o <= 1, ack_done_o=1 for one cycle, bit_cnt=DATA_W, state -> SHIFT (next byte).
- Simultaneous scl_pos and scl_neg strobes: illegal upstream. If they occur, the strobe relevant to the current state wins and the other is ignored.
- sda_o changes only on a scl_neg strobe or on abort/reset, so SDA is never altered while SCL is high.
- data_valid_o and ack_done_o are never high in the same cycle.
- Latency: scl_pos strobe of the last bit -> data_valid_o high 1 cycle later. scl_neg strobe -> sda_o update 1 cycle later.
- Implementation budget: 120-400 lines of RTL.

Test Plan:
- Reset mid-SHIFT after 3 bits: assert reset_i between clock edges -> all outputs at reset values immediately, without waiting for a clock edge.
- en_i=1, ack_en_i=1, shift 0xA5 on 8 scl_pos strobes -> data_o=0xA5, data_valid_o one cycle, byte_cnt_o=1. Next scl_neg -> sda_o=0. scl_pos, then scl_neg -> sda_o=1 and ack_done_o pulse.
- ack_en_i=0, shift 0x3C -> data_o=0x3C; sda_o stays 1 through the ACK slot (NACK); ack_done_o still pulses.
- Back-to-back bytes 0x01, 0xFF, 0x80 with en_i held high -> three data_valid_o pulses with those values, byte_cnt_o=3, three ACK lows on sda_o.
- Abort: en_i drops after 5 bits of 0xF0 -> IDLE next cycle, no data_valid_o, data_o holds its previous value, byte_cnt_o=0. Re-enable and send 0x5A -> data_o=0x5A.
- Glitch immunity: scl_neg strobes during SHIFT and scl_pos strobes during WAIT_ACK -> no shift, state and sda_o unchanged; 256 bytes received -> byte_cnt_o wraps to 0.

Source files
------------

// File: rtl/i2c_data_receiver.sv
// I2C slave byte receiver: samples SDA MSB-first on SCL rising edges, presents the
// byte with a one-cycle valid strobe, then drives ACK/NACK in the ninth SCL period.
module i2c_data_receiver #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              scl_pos_edge_detected_i,
  input  logic              scl_neg_edge_detected_i,
  input  logic              sda_i,
  input  logic              ack_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              sda_o,
  output logic              ack_done_o,
  output logic [7:0]        byte_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_ACK,
    ACK,
    ACK_HOLD
  } state_t;

  localparam logic [3:0] BIT_CNT_INIT = 4'(DATA_W);

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;

  generate
    if (DATA_W > 1) begin : g_wide
      assign shift_next = {shift_q[DATA_W-2:0], sda_i};
    end else begin : g_narrow
      assign shift_next = sda_i;
    end
  endgenerate

  // Each state looks only at its own strobe, so a coincident opposite strobe is ignored.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      bit_cnt      <= BIT_CNT_INIT;
      shift_q      <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sda_o        <= 1'b1;
      ack_done_o   <= 1'b0;
      byte_cnt_o   <= '0;
    end else begin
      data_valid_o <= 1'b0;
      ack_done_o   <= 1'b0;
      if (!en_i) begin
        state      <= IDLE;
        sda_o      <= 1'b1;
        bit_cnt    <= BIT_CNT_INIT;
        shift_q    <= '0;
        byte_cnt_o <= '0;
      end else begin
        case (state)
          IDLE: begin
            sda_o   <= 1'b1;
            bit_cnt <= BIT_CNT_INIT;
            state   <= SHIFT;
          end
          SHIFT: begin
            if (scl_pos_edge_detected_i) begin
              shift_q <= shift_next;
              bit_cnt <= bit_cnt - 4'd1;
              if (bit_cnt == 4'd1) begin
                data_o       <= shift_next;
                data_valid_o <= 1'b1;
                byte_cnt_o   <= byte_cnt_o + 8'd1;
                state        <= WAIT_ACK;
              end
            end
          end
          WAIT_ACK: begin
            if (scl_neg_edge_detected_i) begin
              sda_o <= ~ack_en_i;
              state <= ACK;
            end
          end
          ACK: begin
            if (scl_pos_edge_detected_i) begin
              state <= ACK_HOLD;
            end
          end
          ACK_HOLD: begin
            if (scl_neg_edge_detected_i) begin
              sda_o      <= 1'b1;
              ack_done_o <= 1'b1;
              bit_cnt    <= BIT_CNT_INIT;
              state      <= SHIFT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
